dsp_csr_slave: RTL

- DSP-side Avalon-MM responder at the far end of the registered HPS-to-DSP bridge, in the clk_dsp domain.
- Decodes bridge writes into a control/status register bank for the depth-estimation core.
- Generates start and soft-reset pulses and tracks the core's run state.
- Counts completed frames and run cycles, raises a level interrupt, and returns registered readdata to the bridge.

---
 rtl/dsp_csr_slave.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dsp_csr_slave.sv
// dsp_csr_slave: DSP-side Avalon-MM responder for the depth-estimation core.
// Holds the control/status register bank, generates start and soft-reset
// pulses, tracks run state, counts frames and run cycles, drives a level irq.
// Ports:
//   clk_dsp, reset_n                 clock, async active-low reset
//   avl_write_dsp, avl_chipselect_dsp  write strobe qualifiers
//   avl_address_dsp                  word address
//   avl_byteenable_dsp               byte enables (low WIDTH_DATA/8 bits used)
//   avl_writedata_dsp                write data
//   avl_readdata_dsp                 registered read data (1-cycle latency)
//   dsp_start, dsp_soft_rst          one-cycle pulses to the core
//   dsp_done                         one-cycle completion pulse from the core
//   irq                              level interrupt (IRQ_EN & DONE, registered)
module dsp_csr_slave #(
  parameter int WIDTH_ADDR = 8,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_BE   = 8,
  parameter logic [WIDTH_DATA-1:0] ID_VALUE = 'h4445_5031
) (
  input  logic                  clk_dsp,
  input  logic                  reset_n,
  input  logic                  avl_write_dsp,
  input  logic                  avl_chipselect_dsp,
  input  logic [WIDTH_ADDR-1:0] avl_address_dsp,
  input  logic [WIDTH_BE-1:0]   avl_byteenable_dsp,
  input  logic [WIDTH_DATA-1:0] avl_writedata_dsp,
  output logic [WIDTH_DATA-1:0] avl_readdata_dsp,
  output logic                  dsp_start,
  output logic                  dsp_soft_rst,
  input  logic                  dsp_done,
  output logic                  irq
);
  localparam int NB = WIDTH_DATA / 8;
  localparam logic [WIDTH_ADDR-1:0] A_CTRL    = WIDTH_ADDR'(0);
  localparam logic [WIDTH_ADDR-1:0] A_STATUS  = WIDTH_ADDR'(1);
  localparam logic [WIDTH_ADDR-1:0] A_FRAME   = WIDTH_ADDR'(2);
  localparam logic [WIDTH_ADDR-1:0] A_CYCLE   = WIDTH_ADDR'(3);
  localparam logic [WIDTH_ADDR-1:0] A_SCRATCH = WIDTH_ADDR'(4);
  localparam logic [WIDTH_ADDR-1:0] A_ID      = WIDTH_ADDR'(5);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [WIDTH_DATA-1:0] run_cnt, cycle_cnt, frame_cnt, scratch;
  logic                  irq_en, done_f, err_f;

  // Write decode
  logic wr, ctrl_wr, stat_wr, frame_clr;
  logic start_req, srst_req;
  assign wr        = avl_write_dsp & avl_chipselect_dsp;
  assign ctrl_wr   = wr & (avl_address_dsp == A_CTRL) & avl_byteenable_dsp[0];
  assign stat_wr   = wr & (avl_address_dsp == A_STATUS) & avl_byteenable_dsp[0];
  assign frame_clr = wr & (avl_address_dsp == A_FRAME);
  // Soft reset dominates a START carried in the same write.
  assign srst_req  = ctrl_wr & avl_writedata_dsp[1];
  assign start_req = ctrl_wr & avl_writedata_dsp[0] & ~avl_writedata_dsp[1];

  // FSM: state register
  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_req) state_d = RUN;
      RUN:  if (dsp_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (srst_req) state_d = IDLE;
  end

  // FSM: per-cycle events
  logic start_fire, err_set, done_evt;
  always_comb begin
    start_fire = 1'b0;
    err_set    = 1'b0;
    done_evt   = 1'b0;
    case (state_q)
      IDLE: start_fire = start_req;
      RUN: begin
        err_set  = start_req;
        done_evt = dsp_done & ~srst_req;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt      <= '0;
      cycle_cnt    <= '0;
      frame_cnt    <= '0;
      irq_en       <= 1'b0;
      done_f       <= 1'b0;
      err_f        <= 1'b0;
      dsp_start    <= 1'b0;
      dsp_soft_rst <= 1'b0;
      irq          <= 1'b0;
    end else begin
      dsp_start    <= start_fire;
      dsp_soft_rst <= srst_req;
      irq          <= irq_en & done_f;

      if (srst_req || start_fire)              run_cnt <= '0;
      else if (state_q == RUN && run_cnt != '1) run_cnt <= run_cnt + 1'b1;

      if (done_evt) cycle_cnt <= (run_cnt == '1) ? '1 : run_cnt + 1'b1;

      // A completion in the same cycle as a clear leaves exactly one frame.
      if (done_evt)       frame_cnt <= frame_clr ? WIDTH_DATA'(1) : frame_cnt + 1'b1;
      else if (frame_clr) frame_cnt <= '0;

      // Sticky flags: set beats write-1-to-clear.
      if (done_evt)                              done_f <= 1'b1;
      else if (stat_wr && avl_writedata_dsp[1])  done_f <= 1'b0;
      if (err_set)                               err_f  <= 1'b1;
      else if (stat_wr && avl_writedata_dsp[2])  err_f  <= 1'b0;

      if (ctrl_wr) irq_en <= avl_writedata_dsp[2];
    end
  end

  // Scratch register with per-byte enables
  logic scr_wr;
  assign scr_wr = wr & (avl_address_dsp == A_SCRATCH);
  for (genvar b = 0; b < NB; b++) begin : g_scr
    always_ff @(posedge clk_dsp or negedge reset_n) begin
      if (!reset_n)                           scratch[8*b +: 8] <= 8'h00;
      else if (scr_wr && avl_byteenable_dsp[b]) scratch[8*b +: 8] <= avl_writedata_dsp[8*b +: 8];
    end
  end

  // Read mux, registered every cycle regardless of chipselect
  logic [WIDTH_DATA-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (avl_address_dsp)
      A_CTRL:    rd_mux[2] = irq_en;
      A_STATUS:  rd_mux[2:0] = {err_f, done_f, state_q == RUN};
      A_FRAME:   rd_mux = frame_cnt;
      A_CYCLE:   rd_mux = cycle_cnt;
      A_SCRATCH: rd_mux = scratch;
      A_ID:      rd_mux = ID_VALUE;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) avl_readdata_dsp <= '0;
    else          avl_readdata_dsp <= rd_mux;
  end
endmodule
